vga_sync_monitor: RTL and testbench

Recovers pixel coordinates from a VGA hsync/vsync pair and checks the sync timing against the expected 640x480@60 mode. It sits at the output of the timing generator, clocked from the same clk_i and pixel-strobe. It serves as a loopback checker in the display path and as the front end of a future frame-capture path. It reports lock, recovered counts, a frame-start pulse and a sticky timing error.

---
 rtl/vga_sync_monitor.sv | 178 +++++++++++++++++
 tb/tb_vga_sync_monitor.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor: recovers pixel coordinates from an hsync/vsync pair and checks
// the sync timing against the parameterised VGA mode.
// Define VGA_SYNC_MON_STATS_EN to build the frame and error statistics counters.
module vga_sync_monitor #(
    parameter int H_ACTIVE    = 640,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int H_TOTAL     = 800,
    parameter int V_ACTIVE    = 480,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int V_TOTAL     = 525,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk_i,
    input  logic        arstn_i,
    input  logic        en_i,
    input  logic        vga_hs_i,
    input  logic        vga_vs_i,
    input  logic        err_clr_i,
    output logic [9:0]  hcount_o,
    output logic [9:0]  vcount_o,
    output logic        pixel_enable_o,
    output logic        frame_start_o,
    output logic        locked_o,
    output logic        err_o,
    output logic [15:0] frame_cnt_o,
    output logic [7:0]  err_cnt_o
);
    typedef enum logic [1:0] {ST_SEARCH, ST_MEASURE, ST_LOCKED} state_t;

    localparam logic [10:0] LP_HMAX   = 11'd2047;
    localparam logic [10:0] LP_HLAST  = 11'(H_TOTAL - 1);
    localparam logic [10:0] LP_HSYNC  = 11'(H_SYNC);
    localparam logic [10:0] LP_HSTART = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] LP_HEND   = 11'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [9:0]  LP_VMAX   = 10'd1023;
    localparam logic [9:0]  LP_VLAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0]  LP_VSYNC  = 10'(V_SYNC);
    localparam logic [9:0]  LP_VSTART = 10'(V_SYNC + V_BACK);
    localparam logic [9:0]  LP_VEND   = 10'(V_SYNC + V_BACK + V_ACTIVE);
    localparam logic [2:0]  LP_LOCK   = 3'(LOCK_FRAMES);

    state_t      r_state, w_state_nxt;
    logic        r_hs_d, r_vs_d, r_vs_pend, r_pix, r_fs, r_err;
    logic [10:0] r_hpos, r_hsw, w_hpos_nxt, w_hsw_nxt;
    logic [9:0]  r_vpos, r_vsw, w_vpos_nxt, w_vsw_nxt, r_hcount, r_vcount;
    logic [2:0]  r_good, w_good_nxt;
    logic        w_hs_fall, w_vs_fall, w_hs_rise, w_restart, w_fail, w_err_set, w_pix, w_fs;

    assign w_hs_fall = r_hs_d & ~vga_hs_i;
    assign w_vs_fall = r_vs_d & ~vga_vs_i;
    assign w_hs_rise = ~r_hs_d & vga_hs_i;
    // A frame restarts on the hs edge that coincides with or follows a vs edge
    assign w_restart = w_hs_fall & (r_vs_pend | w_vs_fall);

    // Line length, line saturation, hsync width and frame length/vsync width checks
    assign w_fail = en_i & ((w_hs_fall & (r_hpos != LP_HLAST)) |
                            (~w_hs_fall & (r_hpos == LP_HMAX - 11'd1)) |
                            (w_hs_rise & (r_hsw != LP_HSYNC)) |
                            (w_restart & ((r_vpos != LP_VLAST) | (r_vsw != LP_VSYNC))));

    assign w_hpos_nxt = w_hs_fall ? '0 : (r_hpos == LP_HMAX) ? r_hpos : r_hpos + 11'd1;
    assign w_hsw_nxt  = w_hs_fall ? 11'd1 : (~vga_hs_i && r_hsw != LP_HMAX) ? r_hsw + 11'd1 : r_hsw;
    assign w_vpos_nxt = w_restart ? '0 : w_hs_fall ? r_vpos + 10'd1 : r_vpos;
    assign w_vsw_nxt  = w_restart ? {9'd0, ~vga_vs_i} :
                        (w_hs_fall && !vga_vs_i && r_vsw != LP_VMAX) ? r_vsw + 10'd1 : r_vsw;

    assign w_pix = (w_state_nxt == ST_LOCKED) &&
                   w_hpos_nxt >= LP_HSTART && w_hpos_nxt < LP_HEND &&
                   w_vpos_nxt >= LP_VSTART && w_vpos_nxt < LP_VEND;
    assign w_fs = w_restart & (w_state_nxt == ST_LOCKED);

    // Lock FSM: search for vsync, measure LOCK_FRAMES clean frames, then monitor
    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good;
        w_err_set   = 1'b0;
        if (en_i) begin
            case (r_state)
                ST_SEARCH: begin
                    if (w_vs_fall) begin
                        w_state_nxt = ST_MEASURE;
                        w_good_nxt  = '0;
                    end
                end
                ST_MEASURE: begin
                    if (w_fail) begin
                        w_state_nxt = ST_SEARCH;
                    end else if (w_restart) begin
                        w_good_nxt = r_good + 3'd1;
                        if (w_good_nxt == LP_LOCK) w_state_nxt = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (w_fail) begin
                        w_state_nxt = ST_SEARCH;
                        w_err_set   = 1'b1;
                    end
                end
                default: w_state_nxt = ST_SEARCH;
            endcase
        end
    end

    // Sync sampling, position/width counters and FSM state, advanced on each pixel strobe
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_hs_d    <= 1'b1;
            r_vs_d    <= 1'b1;
            r_hpos    <= '0;
            r_hsw     <= '0;
            r_vpos    <= '0;
            r_vsw     <= '0;
            r_vs_pend <= 1'b0;
            r_state   <= ST_SEARCH;
            r_good    <= '0;
        end else if (en_i) begin
            r_hs_d    <= vga_hs_i;
            r_vs_d    <= vga_vs_i;
            r_hpos    <= w_hpos_nxt;
            r_hsw     <= w_hsw_nxt;
            r_vpos    <= w_vpos_nxt;
            r_vsw     <= w_vsw_nxt;
            r_vs_pend <= w_hs_fall ? 1'b0 : (w_vs_fall | r_vs_pend);
            r_state   <= w_state_nxt;
            r_good    <= w_good_nxt;
        end
    end

    // Registered outputs; frame_start is a single-clk pulse and a new error beats a clear
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_pix    <= 1'b0;
            r_hcount <= '0;
            r_vcount <= '0;
            r_fs     <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_fs  <= en_i & w_fs;
            r_err <= w_err_set | (r_err & ~err_clr_i);
            if (en_i) begin
                r_pix    <= w_pix;
                r_hcount <= w_pix ? 10'(w_hpos_nxt - LP_HSTART) : '0;
                r_vcount <= w_pix ? w_vpos_nxt - LP_VSTART : '0;
            end
        end
    end

    assign hcount_o       = r_hcount;
    assign vcount_o       = r_vcount;
    assign pixel_enable_o = r_pix;
    assign frame_start_o  = r_fs;
    assign locked_o       = (r_state == ST_LOCKED);
    assign err_o          = r_err;

`ifdef VGA_SYNC_MON_STATS_EN
    logic [15:0] r_frame_cnt;
    logic [7:0]  r_err_cnt;

    // Frames seen while locked (wrapping) and failed checks outside search (saturating)
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
        end else if (en_i) begin
            if (w_fs) r_frame_cnt <= r_frame_cnt + 16'd1;
            if (w_fail && r_state != ST_SEARCH && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign frame_cnt_o = r_frame_cnt;
    assign err_cnt_o   = r_err_cnt;
`else
    assign frame_cnt_o = '0;
    assign err_cnt_o   = '0;
`endif
endmodule

// File: tb/tb_vga_sync_monitor.sv
// tb_vga_sync_monitor: reduced-size video mode driven with random pixel strobes,
// every output compared each clock against a behavioural model of the sync rules.
module tb_vga_sync_monitor;
    localparam int HA = 8, HS = 3, HB = 2, HT = 16;
    localparam int VA = 4, VS = 2, VB = 2, VT = 10, LF = 2;
    localparam int SRCH = 0, MEAS = 1, LOCK = 2;

    logic        clk_i = 0, arstn_i = 1, en_i = 0, vga_hs_i = 1, vga_vs_i = 1, err_clr_i = 0;
    logic [9:0]  hcount_o, vcount_o;
    logic        pixel_enable_o, frame_start_o, locked_o, err_o;
    logic [15:0] frame_cnt_o;
    logic [7:0]  err_cnt_o;

    int total = 0, bad = 0;
    int m_ph, m_pv, m_col, m_low, m_row, m_pend, m_vlow, m_mode, m_good, m_err, m_fs, m_fc, m_ec;
    int g_h = 0, g_v = 0, g_len = HT, g_hsw = HS, cyc = 0, en_mode = 1;
    bit inject_long = 0, narrow = 0, after_long = 0, clr_now = 0, clr_on_err = 0;

    vga_sync_monitor #(
        .H_ACTIVE(HA), .H_SYNC(HS), .H_BACK(HB), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_SYNC(VS), .V_BACK(VB), .V_TOTAL(VT), .LOCK_FRAMES(LF)
    ) dut (
        .clk_i(clk_i), .arstn_i(arstn_i), .en_i(en_i), .vga_hs_i(vga_hs_i),
        .vga_vs_i(vga_vs_i), .err_clr_i(err_clr_i), .hcount_o(hcount_o),
        .vcount_o(vcount_o), .pixel_enable_o(pixel_enable_o),
        .frame_start_o(frame_start_o), .locked_o(locked_o), .err_o(err_o),
        .frame_cnt_o(frame_cnt_o), .err_cnt_o(err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph = 1; m_pv = 1; m_col = 0; m_low = 0; m_row = 0; m_pend = 0; m_vlow = 0;
        m_mode = SRCH; m_good = 0; m_err = 0; m_fs = 0; m_fc = 0; m_ec = 0;
    endtask

    task automatic model_sample(input bit hs, input bit vs, input bit en, input bit clr);
        bit hf, vf, hr, rs, ev;
        int was;
        if (!en) begin
            m_fs = 0;
            if (clr) m_err = 0;
            return;
        end
        hf = m_ph == 1 && !hs;
        vf = m_pv == 1 && !vs;
        hr = m_ph == 0 && hs;
        rs = hf && (m_pend == 1 || vf);
        ev = (hf && m_col != HT - 1) || (!hf && m_col == 2046) || (hr && m_low != HS) ||
             (rs && (m_row != VT - 1 || m_vlow != VS));
        was = m_mode;
        if (clr) m_err = 0;
        if (was == SRCH) begin
            if (vf) begin m_mode = MEAS; m_good = 0; end
        end else if (ev) begin
            if (was == LOCK) m_err = 1;
            m_mode = SRCH;
        end else if (rs && was == MEAS) begin
            m_good++;
            if (m_good == LF) m_mode = LOCK;
        end
        m_fs = (rs && m_mode == LOCK) ? 1 : 0;
        if (m_fs == 1) m_fc = (m_fc + 1) % 65536;
        if (was != SRCH && ev && m_ec < 255) m_ec++;
        m_col  = hf ? 0 : (m_col < 2047 ? m_col + 1 : 2047);
        m_low  = hf ? 1 : ((!hs && m_low < 2047) ? m_low + 1 : m_low);
        m_row  = rs ? 0 : hf ? (m_row + 1) % 1024 : m_row;
        m_vlow = rs ? (vs ? 0 : 1) : ((hf && !vs && m_vlow < 1023) ? m_vlow + 1 : m_vlow);
        m_pend = hf ? 0 : vf ? 1 : m_pend;
        m_ph = hs;
        m_pv = vs;
    endtask

    task automatic compare_all();
        bit act;
        act = m_mode == LOCK && m_col >= HS + HB && m_col < HS + HB + HA &&
              m_row >= VS + VB && m_row < VS + VB + VA;
        check("pixel_enable", pixel_enable_o, act);
        check("hcount", hcount_o, act ? m_col - (HS + HB) : 0);
        check("vcount", vcount_o, act ? m_row - (VS + VB) : 0);
        check("frame_start", frame_start_o, m_fs);
        check("locked", locked_o, m_mode == LOCK);
        check("err", err_o, m_err);
`ifdef VGA_SYNC_MON_STATS_EN
        check("frame_cnt", frame_cnt_o, m_fc);
        check("err_cnt", err_cnt_o, m_ec);
`else
        check("frame_cnt", frame_cnt_o, 0);
        check("err_cnt", err_cnt_o, 0);
`endif
    endtask

    task automatic step();
        @(negedge clk_i);
        compare_all();
        cyc++;
        en_i = en_mode == 0 ? 1'($urandom_range(0, 1)) : en_mode == 1 ? (cyc % 4 == 0) : 1'b0;
        err_clr_i = 0;
        vga_hs_i = g_h < g_hsw ? 1'b0 : 1'b1;
        vga_vs_i = g_v < VS ? 1'b0 : 1'b1;
        if (clr_now && en_mode != 2) begin en_i = 1; err_clr_i = 1; clr_now = 0; end
        if (clr_on_err && after_long && g_h == 0) begin en_i = 1; err_clr_i = 1; clr_on_err = 0; end
        @(posedge clk_i);
        model_sample(vga_hs_i, vga_vs_i, en_i, err_clr_i);
        if (en_i) begin
            g_h++;
            if (g_h == g_len) begin
                g_h = 0;
                after_long = g_len != HT;
                g_v = (g_v + 1) % VT;
                g_len = inject_long ? HT + 1 : HT;
                inject_long = 0;
                g_hsw = narrow ? HS - 1 : HS;
            end
        end
    endtask

    task automatic run_samp(input int n);
        int got = 0, guard = 0;
        while (got < n && guard < n * 16) begin
            step();
            if (en_i) got++;
            guard++;
        end
        if (got < n) check("strobe_budget", got, n);
    endtask

    task automatic mid_reset();
        @(negedge clk_i);
        #2;
        en_i = 0;
        err_clr_i = 0;
        arstn_i = 0;
        model_reset();
        #1;
        compare_all();
        @(negedge clk_i);
        compare_all();
        arstn_i = 1;
    endtask

    initial begin
        model_reset();
        #1 arstn_i = 0;
        @(negedge clk_i);
        compare_all();
        arstn_i = 1;
        run_samp(3 * HT * VT + 20);
        #1 check("lock_nominal", locked_o, 1);
        check("no_err_nominal", err_o, 0);
        en_mode = 0;
        run_samp(HT * VT / 3);
        inject_long = 1;
        run_samp(40);
        #1 check("long_line_err", err_o, 1);
        check("long_line_unlock", locked_o, 0);
        run_samp(4 * HT * VT);
        #1 check("relock", locked_o, 1);
        check("err_sticky", err_o, 1);
        clr_now = 1;
        run_samp(3);
        #1 check("err_cleared", err_o, 0);
        inject_long = 1;
        clr_on_err = 1;
        run_samp(40);
        #1 check("set_beats_clear", err_o, 1);
        clr_now = 1;
        run_samp(3);
        narrow = 1;
        run_samp(3 * HT * VT);
        #1 check("narrow_no_lock", locked_o, 0);
        check("narrow_no_err", err_o, 0);
        narrow = 0;
        run_samp(4 * HT * VT + 20);
        #1 check("lock_after_narrow", locked_o, 1);
        run_samp(7);
        en_mode = 2;
        repeat (1000) step();
        en_mode = 0;
        run_samp(100);
        #1 check("resume_locked", locked_o, 1);
        check("resume_no_err", err_o, 0);
        mid_reset();
        run_samp(4 * HT * VT + 20);
        #1 check("lock_after_reset", locked_o, 1);
        @(negedge clk_i);
        compare_all();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
